// File: rtl/alu_seq.sv
// Clocked WIDTH-bit ALU: single-cycle FWD/ADD/AND/OR/SUB/SLL/SRA with flags,
// plus an iterative shift-and-add unsigned multiply behind START/BUSY/DONE.
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             OVERFLOW,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [0:0] {IDLE, MUL} state_t;

  state_t             state;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH:0]     wide;
  logic signed [WIDTH:0] sra_t;
  logic [SHW-1:0]     sh;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [SHW-1:0]     cnt;

  // Shifts run one bit wider so the last bit shifted out lands in the spare bit
  // (and is naturally 0 for a zero shift amount).
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wide    = '0;
    sra_t   = '0;
    sh      = DATA2[SHW-1:0];
    case (SELECT)
      OP_FWD: alu_res = DATA2;
      OP_ADD: begin
        wide    = {1'b0, DATA1} + {1'b0, DATA2};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) && (alu_res[WIDTH-1] != DATA1[WIDTH-1]);
      end
      OP_AND: alu_res = DATA1 & DATA2;
      OP_OR:  alu_res = DATA1 | DATA2;
      OP_SUB: begin
        wide    = {1'b0, DATA1} - {1'b0, DATA2};
        alu_res = wide[WIDTH-1:0];
        alu_c   = ~wide[WIDTH];
        alu_v   = (DATA1[WIDTH-1] != DATA2[WIDTH-1]) && (alu_res[WIDTH-1] != DATA1[WIDTH-1]);
      end
      OP_SLL: begin
        wide    = {1'b0, DATA1} << sh;
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
      end
      OP_SRA: begin
        sra_t   = $signed({DATA1, 1'b0}) >>> sh;
        alu_res = sra_t[WIDTH:1];
        alu_c   = sra_t[0];
      end
      default: ;
    endcase
  end

  assign acc_next = mplier[cnt] ? acc + ({{WIDTH{1'b0}}, mcand} << cnt) : acc;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= IDLE;
      RESULT   <= '0;
      CARRY    <= 1'b0;
      OVERFLOW <= 1'b0;
      DONE     <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (SELECT == OP_MUL) begin
              mcand  <= DATA1;
              mplier <= DATA2;
              acc    <= '0;
              cnt    <= '0;
              state  <= MUL;
            end else begin
              RESULT   <= alu_res;
              CARRY    <= alu_c;
              OVERFLOW <= alu_v;
              DONE     <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH - 1)) begin
            RESULT   <= acc_next[WIDTH-1:0];
            CARRY    <= |acc_next[2*WIDTH-1:WIDTH];
            OVERFLOW <= 1'b0;
            DONE     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ZERO = ~|RESULT;
  assign BUSY = (state == MUL);

endmodule
